forwarding_scoreboard: RTL and testbench
========================================

Name: forwarding_scoreboard

Overview:
- Parametrised successor to the EX-stage forwarding logic.
- Adds N-source, M-stage forwarding with a per-register latency scoreboard that raises a stall when a source register's producer (load, mul/div) has not yet reached the forwarding network.
- Sits in EX between the register-file read data and the ALU operand muxes, and drives the pipeline stall/bubble control.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
NUM_SRC, 2, number of source operands checked per instruction
NUM_FWD, 2, number of forwarding stages; index 0 is the youngest (MEM), index NUM_FWD-1 is the oldest (WB)
REG_ADDR_W, 5, register address width; register 0 is hard-wired zero
XLEN, 32, data width
MAX_LAT, 3, maximum producer latency in cycles
LAT_W, $clog2(MAX_LAT+1), scoreboard counter width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
issue_valid  in  1  EX holds a valid instruction this cycle
flush  in  1  kill the EX instruction this cycle
src_used  in  NUM_SRC  per-source "operand is read" flag
src_addr  in  NUM_SRC*REG_ADDR_W  source register addresses, source i at [i*REG_ADDR_W +: REG_ADDR_W]
rf_data  in  NUM_SRC*XLEN  register-file read data per source
issue_reg_write  in  1  EX instruction writes rd
issue_rd_addr  in  REG_ADDR_W  EX destination register
issue_latency  in  LAT_W  extra cycles until the result reaches stage 0 (0 = single-cycle ALU)
fwd_valid  in  NUM_FWD  stage k holds a register write with valid data
fwd_rd_addr  in  NUM_FWD*REG_ADDR_W  stage destination addresses
fwd_data  in  NUM_FWD*XLEN  stage result data
src_sel  out  NUM_SRC*$clog2(NUM_FWD+1)  0 = register file, k+1 = forwarding stage k
src_data  out  NUM_SRC*XLEN  resolved operand data
stall  out  1  hold IF/ID/EX and insert a bubble into MEM
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. While rst_n=0 at a rising edge: all scoreboard counters cnt[1..2^REG_ADDR_W-1] <= 0 and stall_count <= 0. cnt[0] does not exist and always reads 0.
- Forwarding (combinational), per source i:
  - src_sel[i] = k+1 for the smallest k with fwd_valid[k] && fwd_rd_addr[k]==src_addr[i] && src_addr[i]!=0.
  - Otherwise src_sel[i] = 0.
  - src_data[i] = fwd_data[k] when src_sel[i]=k+1, else rf_data[i].
  - The youngest stage always wins.
  - Forwarding does not depend on src_used or issue_valid.
- Stall (combinational): stall = issue_valid && !flush && (exists i: src_used[i] && src_addr[i]!=0 && cnt[src_addr[i]]!=0).
  - Following reset, with all cnt=0, stall=0.
- Accept: accept = issue_valid && !flush && !stall.
- Scoreboard update at each rising edge with rst_n=1, per register r:
  - If accept && issue_reg_write && issue_rd_addr==r && r!=0: cnt[r] <= issue_latency. Issue wins over decrement; a later writer overwrites an older pending count (WAW, in-order).
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  - Else cnt[r] holds 0.
- Latency meaning:
  - issue_latency=L means the result is forwardable from stage 0 L cycles after EX.
  - A dependant issuing the cycle after is stalled L cycles, then forwards.
  - Load with L=1 gives exactly one load-use bubble.
- Values above MAX_LAT are a protocol error; the bench asserts issue_latency<=MAX_LAT when accept.
- Self-dependency: an instruction reading its own rd uses the old cnt value. The update applies only after the stall check.
- Flush: the EX instruction makes no scoreboard update and stall is deasserted. Pending counts from older instructions keep counting down.
- stall_count: increments by 1 on each edge where stall=1; saturates at all-ones and never wraps.
- Reset mid-operation: all pending counts are discarded in the same edge and stall drops the next cycle.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> stall=0, stall_count=0, src_sel=0, src_data=rf_data.
- Dual-stage priority: fwd_valid=2'b11, both fwd_rd_addr=5, fwd_data={0xBBBB,0xAAAA} (stage1, stage0), src_addr[0]=5 -> src_sel[0]=1, src_data[0]=0xAAAA. Same with src_addr=0 -> src_sel=0.
- Load-use: accept lw x3 (latency 1), next cycle add reading x3 -> stall=1 for exactly 1 cycle. Then stall=0, add accepted with src_sel=1 when stage 0 presents x3. stall_count=1.
- Long latency plus WAW: accept div x7 (latency 3), then an independent op, then add x7 reading x7 -> stalled 2 cycles, not 3. Issue of mul x7 (latency 1) while cnt[7]=2 -> cnt[7] becomes 1.
- Flush: stalled dependant with flush=1 -> stall=0, no cnt write. Pending cnt[3]=2 decrements to 1.
- Saturation and reset mid-operation: CNT_W=4, hold a dependency 20 cycles -> stall_count sticks at 15. Assert rst_n=0 while cnt[9]=3 -> next cycle a reader of x9 has stall=0.

Source files
------------

// File: rtl/forwarding_scoreboard.sv
// EX-stage operand forwarding with a per-register latency scoreboard.
// Picks the youngest matching forwarding stage per source and stalls when a producer is not ready yet.
module forwarding_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int XLEN       = 32,
    parameter int MAX_LAT    = 3,
    parameter int LAT_W      = $clog2(MAX_LAT + 1),
    parameter int CNT_W      = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   issue_valid,
    input  logic                                   flush,
    input  logic [NUM_SRC-1:0]                     src_used,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]          src_addr,
    input  logic [NUM_SRC*XLEN-1:0]                rf_data,
    input  logic                                   issue_reg_write,
    input  logic [REG_ADDR_W-1:0]                  issue_rd_addr,
    input  logic [LAT_W-1:0]                       issue_latency,
    input  logic [NUM_FWD-1:0]                     fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0]          fwd_rd_addr,
    input  logic [NUM_FWD*XLEN-1:0]                fwd_data,
    output logic [NUM_SRC*$clog2(NUM_FWD+1)-1:0]   src_sel,
    output logic [NUM_SRC*XLEN-1:0]                src_data,
    output logic                                   stall,
    output logic [CNT_W-1:0]                       stall_count
);

    localparam int NREG  = 1 << REG_ADDR_W;
    localparam int SEL_W = $clog2(NUM_FWD + 1);

    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;
    logic             dep_hit;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Oldest stage is scanned first so the youngest match overwrites it.
    always_comb begin
        src_sel  = '0;
        src_data = rf_data;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_valid[k]
                    && fwd_rd_addr[k*REG_ADDR_W +: REG_ADDR_W] == src_addr[i*REG_ADDR_W +: REG_ADDR_W]
                    && src_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0) begin
                    src_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    src_data[i*XLEN +: XLEN]  = fwd_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        dep_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_used[i] && src_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0
                && cnt_q[src_addr[i*REG_ADDR_W +: REG_ADDR_W]] != '0) begin
                dep_hit = 1'b1;
            end
        end
    end

    assign stall  = issue_valid && !flush && dep_hit;
    assign accept = issue_valid && !flush && !stall;

    // A new writer replaces any older pending count for the same register.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
            if (r != 0 && accept && issue_reg_write && issue_rd_addr == REG_ADDR_W'(r)) begin
                cnt_d[r] = issue_latency;
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        stall_count_d = stall ? sat_inc(stall_count_q) : stall_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: priority, load-use, long latency/WAW, flush,
// counter saturation and reset while counts are pending.
module tb_forwarding_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int AW      = 5;
    localparam int XLEN    = 32;
    localparam int MAX_LAT = 3;
    localparam int LAT_W   = 2;
    localparam int CNT_W   = 4;
    localparam int SEL_W   = 2;

    logic                      clk;
    logic                      rst_n;
    logic                      issue_valid;
    logic                      flush;
    logic [NUM_SRC-1:0]        src_used;
    logic [NUM_SRC*AW-1:0]     src_addr;
    logic [NUM_SRC*XLEN-1:0]   rf_data;
    logic                      issue_reg_write;
    logic [AW-1:0]             issue_rd_addr;
    logic [LAT_W-1:0]          issue_latency;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD*AW-1:0]     fwd_rd_addr;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic [NUM_SRC*SEL_W-1:0]  src_sel;
    logic [NUM_SRC*XLEN-1:0]   src_data;
    logic                      stall;
    logic [CNT_W-1:0]          stall_count;

    int checks = 0;
    int errors = 0;

    forwarding_scoreboard #(
        .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .REG_ADDR_W(AW), .XLEN(XLEN),
        .MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .flush(flush),
        .src_used(src_used), .src_addr(src_addr), .rf_data(rf_data),
        .issue_reg_write(issue_reg_write), .issue_rd_addr(issue_rd_addr),
        .issue_latency(issue_latency), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr),
        .fwd_data(fwd_data), .src_sel(src_sel), .src_data(src_data), .stall(stall),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && issue_valid && !flush && !stall) begin
            assert (issue_latency <= LAT_W'(MAX_LAT)) else begin
                errors++;
                $error("FAIL issue_latency_range observed=%0d expected<=%0d", issue_latency, MAX_LAT);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one EX instruction; only source 0 is ever read.
    task automatic drive(input logic v, input logic rw, input logic [AW-1:0] rd,
                         input logic [LAT_W-1:0] lat, input logic u0, input logic [AW-1:0] a0);
        issue_valid     = v;
        issue_reg_write = rw;
        issue_rd_addr   = rd;
        issue_latency   = lat;
        src_used        = {1'b0, u0};
        src_addr        = {5'd0, a0};
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        rf_data     = {32'h2222_0002, 32'h1111_0001};
        fwd_valid   = '0;
        fwd_rd_addr = '0;
        fwd_data    = '0;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd6);

        // Reset then idle
        tick();
        tick();
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_stall_count", 64'(stall_count), 64'd0);
        chk("reset_src_sel", 64'(src_sel), 64'd0);
        chk("reset_src_data", 64'(src_data), {32'h2222_0002, 32'h1111_0001});
        rst_n = 1'b1;
        tick();

        // Dual-stage priority
        fwd_valid   = 2'b11;
        fwd_rd_addr = {5'd5, 5'd5};
        fwd_data    = {32'h0000_BBBB, 32'h0000_AAAA};
        drive(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd5);
        chk("prio_sel0", 64'(src_sel[1:0]), 64'd1);
        chk("prio_data0", 64'(src_data[31:0]), 64'h0000_AAAA);
        chk("prio_sel1_x0", 64'(src_sel[3:2]), 64'd0);
        chk("prio_data1_rf", 64'(src_data[63:32]), 64'h2222_0002);
        fwd_valid = 2'b10;
        #1;
        chk("oldstage_sel0", 64'(src_sel[1:0]), 64'd2);
        chk("oldstage_data0", 64'(src_data[31:0]), 64'h0000_BBBB);
        fwd_valid   = 2'b11;
        fwd_rd_addr = {5'd0, 5'd0};
        drive(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0);
        chk("x0_sel0", 64'(src_sel[1:0]), 64'd0);
        chk("x0_data0", 64'(src_data[31:0]), 64'h1111_0001);
        fwd_valid = '0;

        // Load-use: lw x3 (L=1), then add reading x3
        drive(1'b1, 1'b1, 5'd3, 2'd1, 1'b0, 5'd0);
        chk("lw_stall", 64'(stall), 64'd0);
        tick();
        drive(1'b1, 1'b1, 5'd4, 2'd0, 1'b1, 5'd3);
        chk("loaduse_stall", 64'(stall), 64'd1);
        tick();
        fwd_valid   = 2'b01;
        fwd_rd_addr = {5'd0, 5'd3};
        fwd_data    = {32'h0, 32'h0000_0033};
        #1;
        chk("loaduse_release", 64'(stall), 64'd0);
        chk("loaduse_sel0", 64'(src_sel[1:0]), 64'd1);
        chk("loaduse_data0", 64'(src_data[31:0]), 64'h0000_0033);
        chk("loaduse_count", 64'(stall_count), 64'd1);
        tick();
        fwd_valid = '0;
        chk("loaduse_count_after", 64'(stall_count), 64'd1);

        // div x7 (L=3), independent op, then reader of x7: two stall cycles
        drive(1'b1, 1'b1, 5'd7, 2'd3, 1'b0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0);
        chk("indep_stall", 64'(stall), 64'd0);
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'd0, 1'b1, 5'd7);
        chk("div_stall_1", 64'(stall), 64'd1);
        tick();
        chk("div_stall_2", 64'(stall), 64'd1);
        tick();
        chk("div_release", 64'(stall), 64'd0);
        chk("div_count", 64'(stall_count), 64'd3);
        tick();

        // WAW: mul x7 (L=1) issued while cnt[7]=2 shortens the wait to one cycle
        drive(1'b1, 1'b1, 5'd7, 2'd3, 1'b0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd7, 2'd1, 1'b0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'd0, 1'b1, 5'd7);
        chk("waw_stall", 64'(stall), 64'd1);
        tick();
        chk("waw_release", 64'(stall), 64'd0);
        chk("waw_count", 64'(stall_count), 64'd4);
        drive(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0);
        tick();

        // Flush: the killed dependant writes nothing and cnt[3] keeps decrementing
        drive(1'b1, 1'b1, 5'd3, 2'd3, 1'b0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd3, 2'd3, 1'b1, 5'd3);
        chk("preflush_stall", 64'(stall), 64'd1);
        flush = 1'b1;
        #1;
        chk("flush_stall", 64'(stall), 64'd0);
        tick();
        flush = 1'b0;
        drive(1'b1, 1'b0, 5'd0, 2'd0, 1'b1, 5'd3);
        chk("postflush_stall", 64'(stall), 64'd1);
        tick();
        chk("postflush_release", 64'(stall), 64'd0);
        chk("flush_count", 64'(stall_count), 64'd5);
        drive(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0);
        tick();

        // Saturation: each round is a writer of x9 (L=3) then three stalled reader cycles
        for (int rnd = 0; rnd < 5; rnd++) begin
            drive(1'b1, 1'b1, 5'd9, 2'd3, 1'b0, 5'd0);
            tick();
            drive(1'b1, 1'b0, 5'd0, 2'd0, 1'b1, 5'd9);
            for (int c = 0; c < 3; c++) begin
                tick();
            end
            if (rnd == 1) chk("sat_count_mid", 64'(stall_count), 64'd11);
        end
        chk("sat_count_stuck", 64'(stall_count), 64'd15);

        // Reset while cnt[9]=3 discards it
        drive(1'b1, 1'b1, 5'd9, 2'd3, 1'b0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'd0, 1'b1, 5'd9);
        chk("prereset_stall", 64'(stall), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("midreset_stall", 64'(stall), 64'd0);
        chk("midreset_count", 64'(stall_count), 64'd0);
        tick();
        chk("midreset_count_after", 64'(stall_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
